// File: rtl/regfile_writeback_arbiter_if.sv
// Result-source bus between the execution units and the writeback arbiter.
// Source i occupies rd bits [5i+4:5i] and data bits [32i+31:32i].
interface regfile_writeback_arbiter_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [5*NUM_SRC-1:0]  src_rd;
  logic [32*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]    src_ready;

  modport master (output src_valid, output src_rd, output src_data, input src_ready);
  modport slave  (input src_valid, input src_rd, input src_data, output src_ready);
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Aging-priority writeback arbiter with a RAW busy scoreboard; grant is combinational, the
// regfile write port is registered one cycle after transfer, and the regfile never back-pressures.
module regfile_writeback_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int AGE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  regfile_writeback_arbiter_if.slave src,
  output logic        wr_en_o,
  output logic [4:0]  wr_rd_o,
  output logic [31:0] wr_data_o
);
  localparam int AW = $clog2(AGE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic [AW-1:0]      age_q [NUM_SRC];
  logic [AW-1:0]      age_d [NUM_SRC];
  logic [NUM_SRC-1:0] aged;
  logic [NUM_SRC-1:0] grant;
  wb_t                sel;
  logic               xfer;

  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_rd_q, wr_rd_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] busy_q, busy_d;

  // Aged sources pre-empt base priority; within a class the lowest index wins.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      aged[i] = src.src_valid[i] && (age_q[i] == AW'(AGE_MAX));
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && ((|aged) ? aged[i] : src.src_valid[i])) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (rst) begin
      grant = '0;
    end
  end

  assign src.src_ready = grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel.rd   = src.src_rd[5*i +: 5];
        sel.data = src.src_data[32*i +: 32];
      end
    end
    xfer = |grant;
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      age_d[i] = age_q[i];
      if (!src.src_valid[i] || grant[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AW'(AGE_MAX)) begin
        age_d[i] = age_q[i] + AW'(1);
      end
    end
  end

  // rd==0 results are consumed but never written; the port keeps its last real write.
  always_comb begin
    wr_en_d   = xfer && (sel.rd != 5'd0);
    wr_rd_d   = wr_en_d ? sel.rd   : wr_rd_q;
    wr_data_d = wr_en_d ? sel.data : wr_data_q;
  end

  // Set after clear so a same-edge reissue of the retiring rd stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_d) begin
      busy_d[sel.rd] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign rs1_busy_o = (rs1_i != 5'd0) && busy_q[rs1_i];
  assign rs2_busy_o = (rs2_i != 5'd0) && busy_q[rs2_i];
  assign wr_en_o    = wr_en_q;
  assign wr_rd_o    = wr_rd_q;
  assign wr_data_o  = wr_data_q;
endmodule
